// File: rtl/rvv_cmd_queue_pkg.sv
// Shared RVV command types and queue defaults used by the command queue and its neighbours.
package rvv_cmd_queue_pkg;

  localparam int unsigned RVV_CMDQ_DEPTH = 16;

  typedef enum logic [3:0] {
    RVV_OP_VSETVL = 4'd0,
    RVV_OP_VADD   = 4'd1,
    RVV_OP_VSUB   = 4'd2,
    RVV_OP_VMUL   = 4'd3,
    RVV_OP_VMACC  = 4'd4,
    RVV_OP_VAND   = 4'd5,
    RVV_OP_VOR    = 4'd6,
    RVV_OP_VXOR   = 4'd7,
    RVV_OP_VSLL   = 4'd8,
    RVV_OP_VSRL   = 4'd9,
    RVV_OP_VLOAD  = 4'd10,
    RVV_OP_VSTORE = 4'd11,
    RVV_OP_VRED   = 4'd12,
    RVV_OP_VMV    = 4'd13,
    RVV_OP_VCMP   = 4'd14,
    RVV_OP_NOP    = 4'd15
  } rvv_op_e;

  typedef struct packed {
    rvv_op_e     op;
    logic [4:0]  vd;
    logic [4:0]  vs1;
    logic [4:0]  vs2;
    logic        vm;
    logic [31:0] scalar;
  } rvv_cmd_t;

  localparam int unsigned RVV_CMD_W = $bits(rvv_cmd_t);

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n = n + int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/rvv_cmd_queue_checker.sv
// Protocol checks for the command queue: aligned enqueue, in-order retire, overflow visibility.
module rvv_cmd_queue_checker
  import rvv_cmd_queue_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned M     = 2,
  parameter int unsigned DEPTH = RVV_CMDQ_DEPTH
) (
  input logic                         clk,
  input logic                         rst,
  input logic                         flush_i,
  input logic [N-1:0]                 enq_valid_i,
  input logic [M-1:0]                 fire_i,
  input logic [$clog2(DEPTH+1)-1:0]   count_i,
  input logic [$clog2(M+1)-1:0]       n_deq_i
);

  a_enq_aligned: assert property (@(posedge clk) disable iff (rst)
    ((enq_valid_i & (enq_valid_i + N'(1))) == '0))
    else $error("enq_valid_i has a hole: %b", enq_valid_i);

  a_fire_prefix: assert property (@(posedge clk) disable iff (rst)
    ((fire_i & (fire_i + M'(1))) == '0))
    else $error("dequeue fire mask is not a prefix: %b", fire_i);

  // Overflow is a producer error that the queue absorbs by dropping commands.
  c_overflow: cover property (@(posedge clk) disable iff (rst || flush_i)
    ((int'(count_i) - int'(n_deq_i) + int'(popcount(32'(enq_valid_i)))) > int'(DEPTH)));

endmodule

// File: rtl/rvv_cmd_queue_prefix.sv
// In-order handshake prefix: a lane fires only if it and every lower lane is valid and ready.
module rvv_cmd_queue_prefix #(
  parameter int unsigned M = 2
) (
  input  logic [M-1:0]             valid_i,
  input  logic [M-1:0]             ready_i,
  output logic [M-1:0]             fire_o,
  output logic [$clog2(M+1)-1:0]   n_o
);

  localparam int unsigned DW = $clog2(M+1);

  logic run_s;

  // Walk lanes from oldest to youngest, stopping at the first stalled lane.
  always_comb begin
    run_s  = 1'b1;
    fire_o = '0;
    n_o    = '0;
    for (int j = 0; j < int'(M); j++) begin
      run_s     = run_s & valid_i[j] & ready_i[j];
      fire_o[j] = run_s;
      n_o       = n_o + DW'(run_s);
    end
  end

endmodule

// File: rtl/rvv_cmd_queue.sv
// Circular in-order command buffer between the RVV front end and the vector issue stage.
module rvv_cmd_queue
  import rvv_cmd_queue_pkg::*;
#(
  parameter int unsigned N            = 4,
  parameter int unsigned M            = 2,
  parameter int unsigned DEPTH        = RVV_CMDQ_DEPTH,
  parameter int unsigned CAPACITYBITS = $clog2(2*N+1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic [N-1:0]                 enq_valid_i,
  input  logic [N*RVV_CMD_W-1:0]       enq_data_i,
  output logic [CAPACITYBITS-1:0]      capacity_o,
  output logic [M-1:0]                 deq_valid_o,
  output logic [M*RVV_CMD_W-1:0]       deq_data_o,
  input  logic [M-1:0]                 deq_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         overflow_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned DW = $clog2(M+1);

  logic [RVV_CMD_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 overflow_q, overflow_d;

  logic [M-1:0]         fire_s;
  logic [DW-1:0]        n_deq_s;
  logic [CW-1:0]        n_enq_s;
  logic [CW-1:0]        free_s;
  logic [CW-1:0]        n_wr_s;
  logic                 ovf_s;
  int                   room_s;

  rvv_cmd_queue_prefix #(.M(M)) u_prefix (
    .valid_i (deq_valid_o),
    .ready_i (deq_ready_i),
    .fire_o  (fire_s),
    .n_o     (n_deq_s)
  );

  rvv_cmd_queue_checker #(.N(N), .M(M), .DEPTH(DEPTH)) u_checker (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .enq_valid_i (enq_valid_i),
    .fire_i      (fire_s),
    .count_i     (count_q),
    .n_deq_i     (n_deq_s)
  );

  // Next-state pointers and occupancy; free space is measured after this cycle's retires.
  always_comb begin
    n_enq_s    = CW'(popcount(32'(enq_valid_i)));
    free_s     = CW'(DEPTH) - (count_q - CW'(n_deq_s));
    ovf_s      = 1'b0;
    n_wr_s     = n_enq_s;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush_i) begin
      n_wr_s   = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (n_enq_s > free_s) begin
        ovf_s  = 1'b1;
        n_wr_s = free_s;
      end else begin
        ovf_s  = 1'b0;
        n_wr_s = n_enq_s;
      end
      rd_ptr_d   = rd_ptr_q + PW'(n_deq_s);
      wr_ptr_d   = wr_ptr_q + PW'(n_wr_s);
      count_d    = count_q - CW'(n_deq_s) + n_wr_s;
      overflow_d = overflow_q | ovf_s;
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage write: only the accepted prefix of enqueue lanes lands, never past the free space.
  always_ff @(posedge clk) begin
    for (int k = 0; k < int'(N); k++) begin
      if (CW'(k) < n_wr_s) begin
        mem_q[wr_ptr_q + PW'(k)] <= enq_data_i[k*RVV_CMD_W +: RVV_CMD_W];
      end
    end
  end

  // Read lanes index modulo DEPTH, so lanes straddle the wrap point naturally.
  always_comb begin
    deq_valid_o = '0;
    deq_data_o  = '0;
    for (int j = 0; j < int'(M); j++) begin
      deq_valid_o[j]                          = (count_q > CW'(j));
      deq_data_o[j*RVV_CMD_W +: RVV_CMD_W]    = mem_q[rd_ptr_q + PW'(j)];
    end
  end

  // Capacity holds back N slots for commands the front end already has in flight.
  always_comb begin
    room_s = 0;
    if (int'(count_q) + int'(N) < int'(DEPTH)) begin
      room_s = int'(DEPTH) - int'(count_q) - int'(N);
    end else begin
      room_s = 0;
    end
    if (room_s > 2 * int'(N)) begin
      capacity_o = CAPACITYBITS'(2 * N);
    end else begin
      capacity_o = CAPACITYBITS'(room_s);
    end
  end

  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_rvv_cmd_queue.sv
// Randomised scoreboard bench for rvv_cmd_queue against a queue-based reference model.
module tb_rvv_cmd_queue;
  import rvv_cmd_queue_pkg::*;

  localparam int N     = 4;
  localparam int M     = 2;
  localparam int DEPTH = 16;
  localparam int W     = RVV_CMD_W;
  localparam int CAPB  = $clog2(2*N+1);
  localparam int CW    = $clog2(DEPTH+1);

  logic                clk = 1'b0;
  logic                rst;
  logic                flush_i;
  logic [N-1:0]        enq_valid_i;
  logic [N*W-1:0]      enq_data_i;
  logic [CAPB-1:0]     capacity_o;
  logic [M-1:0]        deq_valid_o;
  logic [M*W-1:0]      deq_data_o;
  logic [M-1:0]        deq_ready_i;
  logic [CW-1:0]       count_o;
  logic                overflow_o;

  always #5 clk = ~clk;

  rvv_cmd_queue #(.N(N), .M(M), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .enq_valid_i (enq_valid_i),
    .enq_data_i  (enq_data_i),
    .capacity_o  (capacity_o),
    .deq_valid_o (deq_valid_o),
    .deq_data_o  (deq_data_o),
    .deq_ready_i (deq_ready_i),
    .count_o     (count_o),
    .overflow_o  (overflow_o)
  );

  typedef struct {
    int count;
    int cap;
    int valid;
    bit ovf;
  } stat_t;

  logic [W-1:0] model_q[$];
  logic [W-1:0] sb_q[$];
  stat_t        stat_q[$];
  bit           model_ovf;
  bit           mon_en;
  int           checks;
  int           passes;

  function automatic int exp_cap(int cnt);
    int r;
    r = DEPTH - cnt - N;
    if (r < 0) r = 0;
    if (r > 2*N) r = 2*N;
    return r;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // One cycle: record expected visible status, drive inputs, advance the reference model.
  task automatic step(int n_enq, logic [M-1:0] rdy, bit fl);
    stat_t s;
    int nv, nd, room, acc;
    @(posedge clk); #1;
    s.count = model_q.size();
    s.cap   = exp_cap(s.count);
    nv      = (model_q.size() < M) ? model_q.size() : M;
    s.valid = (1 << nv) - 1;
    s.ovf   = model_ovf;
    stat_q.push_back(s);
    enq_valid_i = N'((1 << n_enq) - 1);
    for (int k = 0; k < N; k++) enq_data_i[k*W +: W] = W'({$urandom(), $urandom()});
    deq_ready_i = rdy;
    flush_i     = fl;
    mon_en      = 1'b1;
    nd = 0;
    while (nd < nv && rdy[nd]) nd++;
    for (int j = 0; j < nd; j++) sb_q.push_back(model_q.pop_front());
    if (fl) begin
      model_q.delete();
    end else begin
      room = DEPTH - model_q.size();
      acc  = (n_enq < room) ? n_enq : room;
      if (n_enq > room) model_ovf = 1'b1;
      for (int k = 0; k < acc; k++) model_q.push_back(enq_data_i[k*W +: W]);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; enq_valid_i = '0; deq_ready_i = '0; flush_i = 1'b0; mon_en = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Monitor: compare status every cycle and pop expected data for each retired lane.
  always @(negedge clk) begin : monitor
    stat_t s;
    bit    run;
    if (mon_en) begin
      if (stat_q.size() == 0) begin
        checks++;
        $display("FAIL status_underrun: got no expected status at %0t", $time);
      end else begin
        s = stat_q.pop_front();
        check("count_o",     64'(count_o),     64'(s.count));
        check("capacity_o",  64'(capacity_o),  64'(s.cap));
        check("deq_valid_o", 64'(deq_valid_o), 64'(s.valid));
        check("overflow_o",  64'(overflow_o),  64'(s.ovf));
      end
      run = 1'b1;
      for (int j = 0; j < M; j++) begin
        run = run & deq_valid_o[j] & deq_ready_i[j];
        if (run) begin
          if (sb_q.size() == 0) begin
            checks++;
            $display("FAIL deq_data_lane%0d: got %0h expected no retire", j, deq_data_o[j*W +: W]);
          end else begin
            check($sformatf("deq_data_lane%0d", j), 64'(deq_data_o[j*W +: W]), 64'(sb_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; flush_i = 1'b0; enq_valid_i = '0; enq_data_i = '0; deq_ready_i = '0;
    mon_en = 1'b0; model_ovf = 1'b0; checks = 0; passes = 0;
    do_reset();
    step(0, 2'b00, 1'b0);
    step(0, 2'b00, 1'b0);
    // first burst and in-order lane data
    step(4, 2'b00, 1'b0);
    step(0, 2'b00, 1'b0);
    step(0, 2'b11, 1'b0);
    // fill to full, then drain two at a time
    step(4, 2'b00, 1'b0);
    step(4, 2'b00, 1'b0);
    step(4, 2'b00, 1'b0);
    step(2, 2'b00, 1'b0);
    step(0, 2'b00, 1'b0);
    for (int i = 0; i < 6; i++) step(0, 2'b11, 1'b0);
    step(0, 2'b00, 1'b0);
    // lane 1 ready alone retires nothing; lane 0 alone retires one
    step(0, 2'b10, 1'b0);
    step(0, 2'b01, 1'b0);
    // flush at count 7 with a simultaneous enqueue
    step(4, 2'b00, 1'b0);
    step(4, 2'b00, 1'b1);
    step(0, 2'b00, 1'b0);
    // forced overflow at count 14
    step(4, 2'b00, 1'b0);
    step(4, 2'b00, 1'b0);
    step(4, 2'b00, 1'b0);
    step(2, 2'b00, 1'b0);
    step(4, 2'b00, 1'b0);
    step(0, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) step(0, 2'b11, 1'b0);
    // reset mid-operation
    do_reset();
    step(0, 2'b00, 1'b0);
    for (int i = 0; i < 600; i++) begin
      int cap, ne;
      logic [M-1:0] r;
      bit fl;
      cap = exp_cap(model_q.size());
      ne  = $urandom_range(0, (cap < N) ? cap : N);
      if ($urandom_range(0, 24) == 0) ne = $urandom_range(0, N);
      fl  = ($urandom_range(0, 39) == 0);
      r   = M'($urandom_range(0, 3));
      if (i == 300) do_reset();
      step(ne, r, fl);
    end
    step(0, 2'b00, 1'b0);
    @(negedge clk); #1;
    mon_en = 1'b0;
    check("scoreboard_drained", 64'(sb_q.size()), 64'(0));
    check("status_drained",     64'(stat_q.size()), 64'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
